mmc1_mapper: RTL and testbench
==============================

MMC1_MAPPER -- requirements
Module: mmc1_mapper

Interface
REQ-001 Parameter PRG_AW, default 17, width of the PRG ROM address (128K).
REQ-002 Parameter CHR_AW, default 16, width of the CHR ROM address (64K).
REQ-003 clock  input  1  system clock (clock_25 domain); all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 prga  input  16  CPU bus address from the PPU/CPU bus block.
REQ-006 prgd  input  8  CPU write data.
REQ-007 prgw  input  1  CPU write strobe; may stay high for several clocks per CPU write.
REQ-008 chra  input  14  PPU render fetch address.
REQ-009 vida  input  14  PPU CPU-port ($2007) video address.
REQ-010 prg_address  output  PRG_AW  banked PRG ROM address.
REQ-011 chr_address  output  CHR_AW  banked CHR address for chra.
REQ-012 vid_address  output  CHR_AW  banked CHR address for vida.
REQ-013 ntc_address  output  12  mirrored nametable address for chra.
REQ-014 ntv_address  output  12  mirrored nametable address for vida.
REQ-015 ctrl  output  5  current control register, for LED/debug.

Function
REQ-016 Write event: wr = prgw & ~prgw_q & prga[15], where prgw_q is prgw delayed by one clock; a held strobe yields exactly one event.
REQ-017 Writes with prga < $8000 shall not change any mapper state.
REQ-018 On wr with prgd[7]=1: shift <= 5'b10000; ctrl <= ctrl | 5'h0C; no other register changes.
REQ-019 On wr with prgd[7]=0 and shift[0]=0: shift <= {prgd[0], shift[4:1]}.
REQ-020 On wr with prgd[7]=0 and shift[0]=1: value = {prgd[0], shift[4:1]} is committed to the register selected by prga[14:13] (00 ctrl, 01 chr0, 10 chr1, 11 prg); shift <= 5'b10000.
REQ-021 Commit therefore occurs on the 5th consecutive data write after a reset marker; the new value affects outputs from the clock after the commit.
REQ-022 PRG mode m = ctrl[3:2]; 16K bank b (3 bits): m=0/1: {prg[2:1], prga[14]}; m=2: prga[14] ? prg[2:0] : 0; m=3: prga[14] ? 7 : prg[2:0].
REQ-023 prg_address = {b, prga[13:0]}, truncated to PRG_AW LSBs; prg[4:3] are ignored.
REQ-024 CHR 4K bank c (4 bits): ctrl[4]=0: {chr0[3:1], a[12]}; ctrl[4]=1: a[12] ? chr1[3:0] : chr0[3:0]; chr_address = {c, a[11:0]} with a = chra; vid_address uses the same mapping with a = vida.
REQ-025 Mirroring page p: ctrl[1:0]=0 -> 0; 1 -> 1; 2 (vertical) -> a[10]; 3 (horizontal) -> a[11]; nt address = {1'b0, p, a[9:0]}, for chra and vida independently.
REQ-026 All address outputs are combinational from the registers and the current inputs (zero latency); only ctrl, chr0, chr1, prg, shift and prgw_q are registered.
REQ-027 Simultaneous event types are impossible (single strobe); a marker write during a partial sequence discards the collected bits.

Reset
REQ-028 On reset_n=0, immediately and regardless of clock: ctrl=5'h0C, chr0=0, chr1=0, prg=0, shift=5'b10000, prgw_q=0.
REQ-029 Reset asserted mid-sequence discards the collected bits; the next five writes form a fresh sequence.
REQ-030 After reset: mode 3, so $C000-$FFFF maps to bank 7 (prg_address for prga=$FFFC is 17'h1FFFC).

Verification
REQ-031 Reset, prga=$FFFC -> prg_address=17'h1FFFC; prga=$8000 -> 17'h00000; ctrl=5'h0C.
REQ-032 Five writes to $E000 with prgd bit0 sequence 1,0,1,0,0 (LSB first) -> prg=5'h05; prga=$8123 -> prg_address=17'h14123.
REQ-033 prgw held high for 4 clocks at $A000 -> shift advances once only; 5 such writes of 1,1,0,0,0 plus ctrl=5'h10 -> chr0=3, chra=$0456 -> chr_address=16'h3456.
REQ-034 Three data writes, then a write of $80 -> shift=5'b10000, ctrl bits [3:2]=11, no register committed; the next five writes commit normally.
REQ-035 ctrl[1:0]=2 -> chra=$2C05 gives ntc_address=12'h405; ctrl[1:0]=3 -> 12'h405 for chra=$2805; ctrl[1:0]=0 -> 12'h005.
REQ-036 reset_n pulsed low between clock edges after two data writes -> all registers return to REQ-028 values asynchronously; writes to $6000 never change state.

Source files
------------

// File: rtl/mmc1_mapper.sv
// MMC1-style bank mapper: a five-write serial port loads the control, CHR and PRG
// bank registers; PRG, CHR and nametable addresses are mapped combinationally.
module mmc1_mapper #(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       prga,
  input  logic [7:0]        prgd,
  input  logic              prgw,
  input  logic [13:0]       chra,
  input  logic [13:0]       vida,
  output logic [PRG_AW-1:0] prg_address,
  output logic [CHR_AW-1:0] chr_address,
  output logic [CHR_AW-1:0] vid_address,
  output logic [11:0]       ntc_address,
  output logic [11:0]       ntv_address,
  output logic [4:0]        ctrl
);

  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;
  logic [4:0] shift;
  logic       prgw_q;
  logic       wr;
  logic [4:0] shift_value;

  // A strobe held over several clocks counts as one write, on its first clock.
  assign wr          = prgw & ~prgw_q & prga[15];
  assign shift_value = {prgd[0], shift[4:1]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= 5'h0C;
      chr0   <= 5'h00;
      chr1   <= 5'h00;
      prg    <= 5'h00;
      shift  <= 5'b10000;
      prgw_q <= 1'b0;
    end else begin
      prgw_q <= prgw;
      if (wr) begin
        if (prgd[7]) begin
          shift <= 5'b10000;
          ctrl  <= ctrl | 5'h0C;
        end else if (!shift[0]) begin
          shift <= shift_value;
        end else begin
          // The marker bit reaching shift[0] means this is the fifth data bit.
          shift <= 5'b10000;
          case (prga[14:13])
            2'b00:   ctrl <= shift_value;
            2'b01:   chr0 <= shift_value;
            2'b10:   chr1 <= shift_value;
            default: prg  <= shift_value;
          endcase
        end
      end
    end
  end

  logic [2:0]  prg_bank;
  logic [16:0] prg_full;

  always_comb begin
    prg_bank = 3'd0;
    case (ctrl[3:2])
      2'd0, 2'd1: prg_bank = {prg[2:1], prga[14]};
      2'd2:       prg_bank = prga[14] ? prg[2:0] : 3'd0;
      default:    prg_bank = prga[14] ? 3'd7 : prg[2:0];
    endcase
  end

  assign prg_full    = {prg_bank, prga[13:0]};
  assign prg_address = PRG_AW'(prg_full);

  function automatic logic [15:0] chr_map(input logic [13:0] a);
    logic [3:0] c;
    c = ctrl[4] ? (a[12] ? chr1[3:0] : chr0[3:0]) : {chr0[3:1], a[12]};
    return {c, a[11:0]};
  endfunction

  function automatic logic [11:0] nt_map(input logic [13:0] a);
    logic p;
    case (ctrl[1:0])
      2'd0:    p = 1'b0;
      2'd1:    p = 1'b1;
      2'd2:    p = a[10];
      default: p = a[11];
    endcase
    return {1'b0, p, a[9:0]};
  endfunction

  assign chr_address = CHR_AW'(chr_map(chra));
  assign vid_address = CHR_AW'(chr_map(vida));
  assign ntc_address = nt_map(chra);
  assign ntv_address = nt_map(vida);

  logic unused_bits;
  assign unused_bits = ^{prgd[6:1], chr0[4], chr1[4], prg[4:3], chra[13], vida[13]};

endmodule

// File: tb/tb_mmc1_mapper.sv
// Directed bench for mmc1_mapper: serial register loads, held strobes, reset
// markers, mirroring modes and asynchronous reset, against hand-computed addresses.
module tb_mmc1_mapper;

  logic        clk;
  logic        reset_n;
  logic [15:0] prga;
  logic [7:0]  prgd;
  logic        prgw;
  logic [13:0] chra;
  logic [13:0] vida;
  logic [16:0] prg_address;
  logic [15:0] chr_address;
  logic [15:0] vid_address;
  logic [11:0] ntc_address;
  logic [11:0] ntv_address;
  logic [4:0]  ctrl;

  int checks_total  = 0;
  int checks_passed = 0;

  mmc1_mapper #(.PRG_AW(17), .CHR_AW(16)) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .prga        (prga),
    .prgd        (prgd),
    .prgw        (prgw),
    .chra        (chra),
    .vida        (vida),
    .prg_address (prg_address),
    .chr_address (chr_address),
    .vid_address (vid_address),
    .ntc_address (ntc_address),
    .ntv_address (ntv_address),
    .ctrl        (ctrl)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    @(posedge clk); #1;
    prga = addr;
    prgd = data;
    prgw = 1'b1;
    repeat (hold) @(posedge clk);
    #1 prgw = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic serial_load(input logic [15:0] addr, input logic [4:0] val, input int hold);
    for (int i = 0; i < 5; i++) cpu_write(addr, {7'b0, val[i]}, hold);
  endtask

  task automatic check_prg(input string tag, input logic [15:0] addr, input logic [16:0] exp);
    prga = addr; #1;
    check(tag, 32'(prg_address), 32'(exp));
  endtask

  task automatic check_chr(input string tag, input logic [13:0] a, input logic [15:0] exp);
    chra = a; #1;
    check(tag, 32'(chr_address), 32'(exp));
  endtask

  task automatic check_vid(input string tag, input logic [13:0] a, input logic [15:0] exp);
    vida = a; #1;
    check(tag, 32'(vid_address), 32'(exp));
  endtask

  task automatic check_ntc(input string tag, input logic [13:0] a, input logic [11:0] exp);
    chra = a; #1;
    check(tag, 32'(ntc_address), 32'(exp));
  endtask

  task automatic check_ntv(input string tag, input logic [13:0] a, input logic [11:0] exp);
    vida = a; #1;
    check(tag, 32'(ntv_address), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0;
    prga = 16'h0000;
    prgd = 8'h00;
    prgw = 1'b0;
    chra = 14'h0000;
    vida = 14'h0000;
    #12;
    check("reset_ctrl", 32'(ctrl), 32'h0C);
    check_prg("reset_prg_fffc", 16'hFFFC, 17'h1FFFC);
    check_prg("reset_prg_8000", 16'h8000, 17'h00000);
    @(negedge clk) reset_n = 1'b1;
    check_chr("reset_chr_0456", 14'h0456, 16'h0456);
    check_ntc("reset_ntc_2c05", 14'h2C05, 12'h005);

    // PRG register = 5, mode 3
    serial_load(16'hE000, 5'h05, 1);
    check_prg("prg5_8123", 16'h8123, 17'h14123);
    check_prg("prg5_c000", 16'hC000, 17'h1C000);

    // held strobes load chr0 = 3, then ctrl = 10
    serial_load(16'hA000, 5'h03, 4);
    serial_load(16'h8000, 5'h10, 1);
    check("ctrl_10", 32'(ctrl), 32'h10);
    check_chr("chr0_3_0456", 14'h0456, 16'h3456);
    check_prg("mode0_c123", 16'hC123, 17'h14123);
    check_prg("mode0_8123", 16'h8123, 17'h10123);

    // partial sequence aborted by a marker write
    for (int i = 0; i < 3; i++) cpu_write(16'hC000, 8'h01, 1);
    cpu_write(16'hC000, 8'h80, 1);
    check("marker_ctrl", 32'(ctrl), 32'h1C);
    check_chr("marker_chr1_untouched", 14'h1456, 16'h0456);
    serial_load(16'hC000, 5'h09, 1);
    check_chr("chr1_9_1456", 14'h1456, 16'h9456);
    check_vid("vid_chr1_1abc", 14'h1ABC, 16'h9ABC);
    check_vid("vid_chr0_0abc", 14'h0ABC, 16'h3ABC);
    check_prg("marker_prg_kept", 16'h8123, 17'h14123);

    // mirroring modes
    serial_load(16'h8000, 5'h02, 1);
    check("ctrl_02", 32'(ctrl), 32'h02);
    check_ntc("vert_2c05", 14'h2C05, 12'h405);
    check_ntv("vert_v2805", 14'h2805, 12'h005);
    check_chr("ctrl02_chr_1456", 14'h1456, 16'h3456);
    serial_load(16'h8000, 5'h03, 1);
    check_ntc("horiz_2805", 14'h2805, 12'h405);
    check_ntv("horiz_v2405", 14'h2405, 12'h005);
    serial_load(16'h8000, 5'h01, 1);
    check_ntc("single1_2005", 14'h2005, 12'h405);
    serial_load(16'h8000, 5'h00, 1);
    check_ntc("single0_2c05", 14'h2C05, 12'h005);

    // asynchronous reset between edges after two data writes
    cpu_write(16'hE000, 8'h01, 1);
    cpu_write(16'hE000, 8'h01, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("async_ctrl", 32'(ctrl), 32'h0C);
    check_prg("async_prg_fffc", 16'hFFFC, 17'h1FFFC);
    reset_n = 1'b1;
    check_chr("async_chr0_cleared", 14'h0456, 16'h0456);
    check_prg("async_prg_8123", 16'h8123, 17'h00123);
    serial_load(16'hE000, 5'h03, 1);
    check_prg("fresh_prg3", 16'h8123, 17'h0C123);

    // writes below $8000 are ignored, including markers
    serial_load(16'h6000, 5'h1F, 1);
    cpu_write(16'h6000, 8'h80, 1);
    check_prg("low_write_prg", 16'h8123, 17'h0C123);
    check("low_write_ctrl", 32'(ctrl), 32'h0C);
    serial_load(16'hE000, 5'h06, 1);
    check_prg("after_low_prg6", 16'h8123, 17'h18123);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
